// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, default
// memory geometry and the requester port indices.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_MEM_DEPTH = 512;
    localparam int DEF_MEM_LAT   = 1;

    // Latency counter only needs to hold 1..7.
    localparam int LAT_CNT_W = 3;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the priority
// pointer lives in the parent so it only advances on real acceptances.
module rr_arb2
    import data_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester wins, a tie goes to the pointed-at port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant = 2'b00;
        if (en) begin
            if (req[PORT_CPU] && (!req[PORT_DBG] || prio == 1'(PORT_CPU))) begin
                grant[PORT_CPU] = 1'b1;
            end else if (req[PORT_DBG]) begin
                grant[PORT_DBG] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the CPU load/store stage
// (port 0) and the debug/DMA loader (port 1). One access at a time: grant,
// strobe for one cycle, wait the memory latency, pulse a response.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              REQ0_VALID,
    input  logic              REQ0_WRITE,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_WDATA,
    output logic              REQ0_READY,
    output logic              RSP0_VALID,
    output logic [DATA_W-1:0] RSP0_RDATA,
    output logic              RSP0_ERR,

    input  logic              REQ1_VALID,
    input  logic              REQ1_WRITE,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_WDATA,
    output logic              REQ1_READY,
    output logic              RSP1_VALID,
    output logic [DATA_W-1:0] RSP1_RDATA,
    output logic              RSP1_ERR,

    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITE_DATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    input  logic [DATA_W-1:0] MEM_READ_DATA
);

    localparam logic [ADDR_W-1:0]    DEPTH_LIM = ADDR_W'(MEM_DEPTH);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE   = LAT_CNT_W'(1);

    state_t                      state_q, state_d;
    logic                        prio_q, prio_d;
    logic                        owner_q, owner_d;
    logic                        write_q, write_d;
    logic [LAT_CNT_W-1:0]        cnt_q, cnt_d;
    logic                        mem_read_q, mem_read_d;
    logic                        mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]                  rsp_valid_q, rsp_valid_d;
    logic [1:0]                  rsp_err_q, rsp_err_d;
    logic [1:0][DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic [1:0]                  grant;
    logic                        sel;
    logic                        req_write;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;

    rr_arb2 u_arb (
        .req   ({REQ1_VALID, REQ0_VALID}),
        .prio  (prio_q),
        .en    (state_q == IDLE),
        .grant (grant)
    );

    assign REQ0_READY = grant[PORT_CPU];
    assign REQ1_READY = grant[PORT_DBG];

    // Fields of whichever port won this cycle.
    assign sel       = grant[PORT_DBG];
    assign req_write = sel ? REQ1_WRITE : REQ0_WRITE;
    assign req_addr  = sel ? REQ1_ADDR  : REQ0_ADDR;
    assign req_wdata = sel ? REQ1_WDATA : REQ0_WDATA;

    // Next-state and next-output computation; every visible output is registered.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 2'b00;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = sel;
                    write_d = req_write;
                    prio_d  = ~sel;
                    if (req_addr >= DEPTH_LIM) begin
                        // Out of range: answer immediately, never touch the memory.
                        state_d        = RESP;
                        rsp_valid_d[sel] = 1'b1;
                        rsp_err_d[sel]   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_read_d  = ~req_write;
                        mem_write_d = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d              = RESP;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d[owner_q] = write_q ? '0 : MEM_READ_DATA;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'(PORT_CPU);
            owner_q     <= 1'b0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign MEM_READ       = mem_read_q;
    assign MEM_WRITE      = mem_write_q;
    assign MEM_ADDRESS    = mem_addr_q;
    assign MEM_WRITE_DATA = mem_wdata_q;

    assign RSP0_VALID = rsp_valid_q[PORT_CPU];
    assign RSP0_ERR   = rsp_err_q[PORT_CPU];
    assign RSP0_RDATA = rsp_rdata_q[PORT_CPU];
    assign RSP1_VALID = rsp_valid_q[PORT_DBG];
    assign RSP1_ERR   = rsp_err_q[PORT_DBG];
    assign RSP1_RDATA = rsp_rdata_q[PORT_DBG];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 512-word, latency-1 memory
// model whose word i initially holds i.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        REQ0_VALID = 1'b0, REQ0_WRITE = 1'b0;
    logic [31:0] REQ0_ADDR = '0, REQ0_WDATA = '0;
    logic        REQ1_VALID = 1'b0, REQ1_WRITE = 1'b0;
    logic [31:0] REQ1_ADDR = '0, REQ1_WDATA = '0;
    logic        REQ0_READY, RSP0_VALID, RSP0_ERR;
    logic        REQ1_READY, RSP1_VALID, RSP1_ERR;
    logic [31:0] RSP0_RDATA, RSP1_RDATA;
    logic [31:0] MEM_ADDRESS, MEM_WRITE_DATA, MEM_READ_DATA;
    logic        MEM_READ, MEM_WRITE;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    logic [31:0] mem [0:511];
    bit          mem_init;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR),
        .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY), .RSP0_VALID(RSP0_VALID),
        .RSP0_RDATA(RSP0_RDATA), .RSP0_ERR(RSP0_ERR),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR),
        .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY), .RSP1_VALID(RSP1_VALID),
        .RSP1_RDATA(RSP1_RDATA), .RSP1_ERR(RSP1_ERR),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_READ_DATA(MEM_READ_DATA)
    );

    // Single-port memory model: loads word i = i on the first edge, then
    // writes and registers read data one cycle after the strobe.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
            mem_init <= 1'b1;
        end else begin
            if (MEM_WRITE) mem[MEM_ADDRESS[8:0]] <= MEM_WRITE_DATA;
            if (MEM_READ) MEM_READ_DATA <= mem[MEM_ADDRESS[8:0]];
        end
    end

    // Count strobe cycles seen by the memory.
    always @(posedge clk) begin
        if (MEM_READ || MEM_WRITE) strobes <= strobes + 1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int port, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            REQ0_VALID = v; REQ0_WRITE = w; REQ0_ADDR = a; REQ0_WDATA = d;
        end else begin
            REQ1_VALID = v; REQ1_WRITE = w; REQ1_ADDR = a; REQ1_WDATA = d;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step(); step();
        checks++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA} !== 66'd0) begin
            errors++; $display("FAIL reset_mem: got %h want 0", {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA});
        end
        checks++;
        if ({RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID, RSP1_ERR, RSP1_RDATA} !== 68'd0) begin
            errors++; $display("FAIL reset_rsp: got %h want 0", {RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID, RSP1_ERR, RSP1_RDATA});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({REQ1_READY, REQ0_READY, MEM_READ} !== 3'b000) begin
            errors++; $display("FAIL reset_idle: got %b want 000", {REQ1_READY, REQ0_READY, MEM_READ});
        end
    endtask

    task automatic test_single_read();
        drive(0, 1, 0, 5, 0);
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL rd_ready0: got %b want 1", REQ0_READY); end
        step();
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS} !== {2'b10, 32'd5}) begin
            errors++; $display("FAIL rd_issue: got %b %b %0d want 1 0 5", MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end
        step();
        checks++;
        if ({MEM_READ, MEM_ADDRESS, RSP0_VALID} !== {1'b0, 32'd5, 1'b0}) begin
            errors++; $display("FAIL rd_wait: got rd=%b addr=%0d rsp=%b want 0 5 0", MEM_READ, MEM_ADDRESS, RSP0_VALID);
        end
        step();
        checks++;
        if ({RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID} !== {2'b10, 32'd5, 1'b0}) begin
            errors++; $display("FAIL rd_resp: got v=%b e=%b d=%0d v1=%b want 1 0 5 0", RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID);
        end
        step();
        checks++;
        if ({RSP0_VALID, RSP0_RDATA} !== 33'd0) begin
            errors++; $display("FAIL rd_pulse: got v=%b d=%0d want 0 0", RSP0_VALID, RSP0_RDATA);
        end
    endtask

    task automatic test_write_read_p1();
        drive(1, 1, 1, 100, 32'hDEADBEEF);
        #1;
        checks++;
        if ({REQ1_READY, REQ0_READY} !== 2'b10) begin errors++; $display("FAIL wr_ready1: got %b want 10", {REQ1_READY, REQ0_READY}); end
        step();
        drive(1, 0, 0, 0, 0);
        checks++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA} !== {2'b01, 32'd100, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_issue: got %b %b %0d %h want 0 1 100 deadbeef", MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA);
        end
        step(); step();
        checks++;
        if ({RSP1_VALID, RSP1_ERR, RSP1_RDATA, RSP0_VALID} !== {2'b10, 32'd0, 1'b0}) begin
            errors++; $display("FAIL wr_resp: got v=%b e=%b d=%h v0=%b want 1 0 0 0", RSP1_VALID, RSP1_ERR, RSP1_RDATA, RSP0_VALID);
        end
        step();
        drive(1, 1, 0, 100, 0);
        step();
        drive(1, 0, 0, 0, 0);
        step(); step();
        checks++;
        if ({RSP1_VALID, RSP1_RDATA} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_readback: got v=%b d=%h want 1 deadbeef", RSP1_VALID, RSP1_RDATA);
        end
        step();
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        drive(0, 1, 0, 10, 0);
        drive(1, 1, 0, 20, 0);
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic        exp_port;
            logic [1:0]  exp_oh;
            logic [31:0] exp_data, got_data;
            exp_port = k[0];
            exp_oh   = exp_port ? 2'b10 : 2'b01;
            exp_data = exp_port ? 32'd20 : 32'd10;
            #1;
            checks++;
            if ({REQ1_READY, REQ0_READY} !== exp_oh) begin
                errors++; $display("FAIL cont_grant%0d: got %b want %b", k, {REQ1_READY, REQ0_READY}, exp_oh);
            end
            step();
            if (k == 3) begin
                drive(0, 0, 0, 0, 0);
                drive(1, 0, 0, 0, 0);
            end
            #1;
            checks++;
            if ({REQ1_READY, REQ0_READY} !== 2'b00) begin
                errors++; $display("FAIL cont_busy%0d: got %b want 00", k, {REQ1_READY, REQ0_READY});
            end
            step(); step();
            got_data = exp_port ? RSP1_RDATA : RSP0_RDATA;
            checks++;
            if ({RSP1_VALID, RSP0_VALID} !== exp_oh || got_data !== exp_data) begin
                errors++; $display("FAIL cont_rsp%0d: got v=%b d=%0d want v=%b d=%0d", k, {RSP1_VALID, RSP0_VALID}, got_data, exp_oh, exp_data);
            end
            step();
        end
    endtask

    task automatic test_out_of_range();
        int s0;
        s0 = strobes;
        drive(0, 1, 0, 512, 0);
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", REQ0_READY); end
        step();
        drive(0, 1, 0, 32'hFFFFFFFF, 0);
        checks++;
        if ({RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID, MEM_READ, MEM_WRITE} !== {2'b11, 32'd0, 3'b000}) begin
            errors++; $display("FAIL oor_resp512: got v=%b e=%b d=%0d v1=%b rd=%b wr=%b want 1 1 0 0 0 0",
                               RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID, MEM_READ, MEM_WRITE);
        end
        #1;
        checks++;
        if (REQ0_READY !== 1'b0) begin errors++; $display("FAIL oor_resp_busy: got %b want 0", REQ0_READY); end
        step();
        #1;
        checks++;
        if ({RSP0_VALID, REQ0_READY} !== 2'b01) begin
            errors++; $display("FAIL oor_free: got v=%b rdy=%b want 0 1", RSP0_VALID, REQ0_READY);
        end
        step();
        drive(0, 1, 0, 511, 0);
        checks++;
        if ({RSP0_VALID, RSP0_ERR, RSP0_RDATA} !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL oor_respmax: got v=%b e=%b d=%0d want 1 1 0", RSP0_VALID, RSP0_ERR, RSP0_RDATA);
        end
        step();
        checks++;
        if (strobes !== s0) begin errors++; $display("FAIL oor_no_strobe: got %0d want %0d", strobes, s0); end
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL oor_511_ready: got %b want 1", REQ0_READY); end
        step();
        drive(0, 0, 0, 0, 0);
        step(); step();
        checks++;
        if ({RSP0_VALID, RSP0_ERR, RSP0_RDATA} !== {2'b10, 32'd511}) begin
            errors++; $display("FAIL oor_511: got v=%b e=%b d=%0d want 1 0 511", RSP0_VALID, RSP0_ERR, RSP0_RDATA);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        drive(0, 1, 0, 7, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, RSP0_VALID, RSP0_ERR, RSP0_RDATA, RSP1_VALID, RSP1_ERR, RSP1_RDATA} !== 134'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got addr=%0d rd=%b v0=%b d0=%0d want all 0", MEM_ADDRESS, MEM_READ, RSP0_VALID, RSP0_RDATA);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (RSP0_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: got %b want 0", RSP0_VALID); end
        drive(0, 1, 0, 30, 0);
        drive(1, 1, 0, 40, 0);
        #1;
        checks++;
        if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_prio: got %b want 01", {REQ1_READY, REQ0_READY});
        end
        step();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step(); step();
        checks++;
        if ({RSP0_VALID, RSP0_RDATA} !== {1'b1, 32'd30}) begin
            errors++; $display("FAIL rst_mid_after: got v=%b d=%0d want 1 30", RSP0_VALID, RSP0_RDATA);
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 50, 0);
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL held_ready0: got %b want 1", REQ0_READY); end
        step();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 60, 32'h12345678);
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (REQ1_READY !== 1'b0) begin errors++; $display("FAIL held_busy_c%0d: got %b want 0", c, REQ1_READY); end
            if (c == 3) begin
                checks++;
                if ({RSP0_VALID, RSP0_RDATA} !== {1'b1, 32'd50}) begin
                    errors++; $display("FAIL held_rsp0: got v=%b d=%0d want 1 50", RSP0_VALID, RSP0_RDATA);
                end
            end
            step();
        end
        #1;
        checks++;
        if (REQ1_READY !== 1'b1) begin errors++; $display("FAIL held_ready1: got %b want 1", REQ1_READY); end
        step();
        drive(1, 0, 0, 0, 0);
        checks++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA} !== {2'b01, 32'd60, 32'h12345678}) begin
            errors++; $display("FAIL held_issue: got %b %b %0d %h want 0 1 60 12345678", MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA);
        end
        step(); step();
        checks++;
        if ({RSP1_VALID, RSP1_ERR, RSP1_RDATA} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL held_rsp1: got v=%b e=%b d=%h want 1 0 0", RSP1_VALID, RSP1_ERR, RSP1_RDATA);
        end
        step();
        drive(0, 1, 0, 60, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step(); step();
        checks++;
        if ({RSP0_VALID, RSP0_RDATA} !== {1'b1, 32'h12345678}) begin
            errors++; $display("FAIL b2b_readback: got v=%b d=%h want 1 12345678", RSP0_VALID, RSP0_RDATA);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read_p1();
        test_contention();
        test_out_of_range();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-ported 512-word data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/DMA loader.
- Arbitrates round-robin and sequences exactly one MEM_READ or MEM_WRITE strobe per access.
- Waits the memory's fixed read latency, then returns data or a write acknowledge to the winning requester.
- Sits between the requesters and the data memory; it is the only driver of the memory's control and address inputs.

Parameters:
- DATA_W, 32, data width of memory words and requester data.
- ADDR_W, 32, requester and memory address width; addresses are word indices.
- MEM_DEPTH, 512, number of valid words; addresses >= MEM_DEPTH are out of range.
- MEM_LAT, 1, cycles from the strobe edge until MEM_READ_DATA is valid; legal range is 1 to 7.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- REQ0_VALID / REQ1_VALID  in  1  request pending.
- REQ0_WRITE / REQ1_WRITE  in  1  1 = write, 0 = read.
- REQ0_ADDR / REQ1_ADDR  in  ADDR_W  word address.
- REQ0_WDATA / REQ1_WDATA  in  DATA_W  write data.
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle when VALID is also 1.
- RSP0_VALID / RSP1_VALID  out  1  one-cycle response pulse.
- RSP0_RDATA / RSP1_RDATA  out  DATA_W  read data; 0 for writes and errors.
- RSP0_ERR / RSP1_ERR  out  1  address out of range; qualified by RSPx_VALID.
- MEM_ADDRESS  out  ADDR_W  to the memory's ADDRESS input.
- MEM_WRITE_DATA  out  DATA_W  to the memory's WRITE_DATA input.
- MEM_READ  out  1  to the memory's MEM_READ input.
- MEM_WRITE  out  1  to the memory's MEM_WRITE input.
- MEM_READ_DATA  in  DATA_W  from the memory's READ_DATA output.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE and the priority pointer goes to 0.
  - All outputs go to 0: MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, RSPx_VALID, RSPx_RDATA, RSPx_ERR.
  - Reset mid-operation abandons the access with no response. A write already strobed may have landed in memory.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - REQx_READY = (state==IDLE) & grant_x, combinational. Nothing else is combinational to an output.
  - If only one VALID is high, that port is granted. If both are high, the port named by the priority pointer is granted.
  - On acceptance, register owner, write, addr and wdata.
  - If addr >= MEM_DEPTH, go to RESP with err=1 and issue no strobe. Otherwise go to ISSUE.
  - The priority pointer moves to the other port after every accepted request, including error requests.
- ISSUE:
  - Exactly one cycle with MEM_READ=~write, MEM_WRITE=write, and MEM_ADDRESS/MEM_WRITE_DATA taken from the captured request.
  - The memory samples the strobe at the closing edge.
  - Load the latency counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Strobes are 0; MEM_ADDRESS and MEM_WRITE_DATA hold their values.
  - Decrement the counter each cycle.
  - At the edge where the counter reaches 0, capture MEM_READ_DATA for reads (0 for writes), then go to RESP.
- RESP:
  - RSP<owner>_VALID=1 for one cycle with RDATA/ERR; the other port's RSP outputs stay 0. Then go to IDLE.
- Latency and throughput:
  - With a request accepted in cycle 0, the response pulse is in cycle 2+MEM_LAT (cycle 3 by default).
  - Minimum repeat interval is 3+MEM_LAT cycles.
  - An error request responds in cycle 1 and frees the arbiter for acceptance in cycle 2.
- Requester rules:
  - Hold the request fields stable while VALID=1 and READY=0.
  - VALID may be withdrawn before acceptance with no effect.
  - No new request is accepted while in ISSUE, WAIT or RESP.
- Boundaries:
  - Address MEM_DEPTH-1 (511) is legal; 512 and above, including 0xFFFFFFFF, are errors.
  - The comparison is a full ADDR_W unsigned compare, with no truncation or wrap.
  - A read always returns the current memory contents; the block does no caching or forwarding.
  - A back-to-back write then read to the same address returns the new value because accesses are serialised.

Decomposition:
- Package data_mem_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - the default MEM_DEPTH and MEM_LAT constants;
  - the port-index constants PORT_CPU=0 and PORT_DBG=1.
- One sub-module, rr_arb2:
  - inputs: req[1:0], prio, en;
  - output: one-hot grant[1:0];
  - purely combinational, with the priority pointer register kept in the parent.

Test Plan:
- Reset then single read: after reset, REQ0 read addr 5 -> READY0 in cycle 0; MEM_READ=1 with MEM_ADDRESS=5 in cycle 1 only; RSP0_VALID with RDATA=5 in cycle 3. The memory is initialised so that word i holds i.
- Write then read, port 1: write addr 100 data 0xDEADBEEF -> RSP1_VALID, ERR=0, RDATA=0 in cycle 3; following read of addr 100 -> RDATA=0xDEADBEEF.
- Contention: both VALID held from reset, reading addrs 10 and 20 -> grants alternate 0,1,0,1 (pointer starts at 0); responses RDATA 10,20,10,20 at 4-cycle spacing.
- Out of range: REQ0 read addr 512 -> RSP0_VALID, ERR=1, RDATA=0 in cycle 1; MEM_READ/MEM_WRITE never asserted. Addr 511 -> ERR=0, RDATA=511.
- Reset mid-op: assert rst_n=0 during WAIT of a port-0 read -> all outputs 0 next cycle; no RSP0_VALID ever; next request after release is granted to port 0.
- Held request: REQ1 VALID raised during port-0 ISSUE -> READY1 stays 0 until IDLE; its fields are captured unchanged and it completes correctly.
